// File: rtl/prog_counter_pkg.sv
// Shared definitions for the programmable down-counter: run-state encoding and
// the per-edge operation priority order.
package prog_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_e;

    // Lower value wins when several operations are requested on the same edge.
    localparam int unsigned PRIO_RESET  = 0;
    localparam int unsigned PRIO_LATCH  = 1;
    localparam int unsigned PRIO_DIVIDE = 2;
    localparam int unsigned PRIO_DEC    = 3;

    function automatic logic state_is_legal(input state_e s);
        return (s == ST_IDLE) || (s == ST_RUN) || (s == ST_EXPIRED);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Decrement prescaler: emits one tick every (prescale+1) enabled cycles.
module tick_prescaler #(
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pre_q, pre_d;

    // >= so that lowering prescale below the running count ticks on the next enable
    assign tick = en & (pre_q >= prescale);

    always_comb begin
        pre_d = pre_q;
        if (clear) begin
            pre_d = '0;
        end else if (tick) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = pre_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/prog_down_counter.sv
// Loadable down-counter with prescaled decrement, halving, auto-reload,
// terminal-count pulse and an IDLE/RUN/EXPIRED run-state FSM.
module prog_down_counter
    import prog_counter_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      in,
    input  logic                  latch,
    input  logic                  dec,
    input  logic                  divide_by_two,
    input  logic                  auto_reload,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  zero,
    output logic                  tc_pulse,
    output logic                  busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             tick;
    logic [WIDTH-1:0] half;

    // Latch and divide both pre-empt the decrement, so the prescaler must not advance.
    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clock    (clock),
        .reset    (reset),
        .clear    (latch),
        .en       (dec & ~latch & ~divide_by_two),
        .prescale (prescale),
        .tick     (tick)
    );

    assign half = count_q >> 1;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (!state_is_legal(state_q)) begin
            state_d = ST_IDLE;
        end

        if (latch) begin
            count_d  = in;
            reload_d = in;
            state_d  = (in != '0) ? ST_RUN : ST_IDLE;
        end else if (divide_by_two) begin
            count_d = half;
            if ((count_q != '0) && (half == '0)) begin
                state_d = ST_EXPIRED;
            end
        end else if (tick) begin
            unique case (state_q)
                ST_RUN: begin
                    if (count_q > WIDTH'(1)) begin
                        count_d = count_q - 1'b1;
                    end else begin
                        count_d = '0;
                        state_d = ST_EXPIRED;
                        tc_d    = (count_q == WIDTH'(1));
                    end
                end
                ST_EXPIRED: begin
                    if (auto_reload && (reload_q != '0)) begin
                        count_d = reload_q;
                        state_d = ST_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign count    = count_q;
    assign zero     = (count_q == '0);
    assign tc_pulse = tc_q;
    assign busy     = (state_q == ST_RUN);

endmodule

// File: tb/tb_prog_down_counter.sv
// Scoreboard bench for prog_down_counter (WIDTH=8, PRESCALE_W=4).
module tb_prog_down_counter;
    import prog_counter_pkg::*;

    logic       clock = 1'b0;
    logic       reset, latch, dec, divide_by_two, auto_reload;
    logic [7:0] in;
    logic [3:0] prescale;
    logic [7:0] count;
    logic       zero, tc_pulse, busy;

    prog_down_counter #(.WIDTH(8), .PRESCALE_W(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .in            (in),
        .latch         (latch),
        .dec           (dec),
        .divide_by_two (divide_by_two),
        .auto_reload   (auto_reload),
        .prescale      (prescale),
        .count         (count),
        .zero          (zero),
        .tc_pulse      (tc_pulse),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] count;
        logic       zero;
        logic       tc;
        logic       busy;
    } exp_t;

    exp_t sb[$];

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state
    logic [7:0] m_count, m_reload;
    logic [3:0] m_pre;
    state_e     m_state;
    logic       m_tc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        logic [7:0] nc;
        m_tc = 1'b0;
        if (reset) begin
            m_count = 0; m_reload = 0; m_pre = 0; m_state = ST_IDLE;
        end else if (latch) begin
            m_count = in; m_reload = in; m_pre = 0;
            m_state = (in != 0) ? ST_RUN : ST_IDLE;
        end else if (divide_by_two) begin
            nc = m_count >> 1;
            if (m_count != 0 && nc == 0) m_state = ST_EXPIRED;
            m_count = nc;
        end else if (dec) begin
            if (m_pre >= prescale) begin
                m_pre = 0;
                if (m_state == ST_RUN) begin
                    if (m_count > 1) m_count = m_count - 1;
                    else begin
                        if (m_count == 1) m_tc = 1'b1;
                        m_count = 0;
                        m_state = ST_EXPIRED;
                    end
                end else if (m_state == ST_EXPIRED && auto_reload && m_reload != 0) begin
                    m_count = m_reload;
                    m_state = ST_RUN;
                end
            end else begin
                m_pre = m_pre + 1;
            end
        end
    endtask

    // Drive one cycle of inputs, predict, then compare after the edge.
    task automatic step(input logic r, input logic l, input logic d, input logic dv,
                        input logic ar, input logic [7:0] v, input logic [3:0] ps);
        exp_t e;
        @(negedge clock);
        reset = r; latch = l; dec = d; divide_by_two = dv; auto_reload = ar;
        in = v; prescale = ps;
        model_edge();
        e.count = m_count; e.zero = (m_count == 0); e.tc = m_tc; e.busy = (m_state == ST_RUN);
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
        end else begin
            e = sb.pop_front();
            check("count", count, e.count);
            check("zero", zero, e.zero);
            check("tc_pulse", tc_pulse, e.tc);
            check("busy", busy, e.busy);
        end
    endtask

    int unsigned tc_seen;
    int unsigned guard;

    initial begin
        reset = 1; latch = 0; dec = 0; divide_by_two = 0; auto_reload = 0;
        in = 0; prescale = 0;
        m_count = 'x; m_reload = 'x; m_pre = 'x; m_state = ST_IDLE; m_tc = 0;

        // 1. reset
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check("rst_count", count, 0);
        check("rst_zero", zero, 1);
        check("rst_busy", busy, 0);

        // 2. count 9 down to 0 at full rate
        step(0, 1, 1, 0, 0, 9, 0);
        check("t2_load", count, 9);
        tc_seen = 0;
        for (int i = 8; i >= 0; i--) begin
            step(0, 0, 1, 0, 0, 0, 0);
            check("t2_seq", count, i);
            if (tc_pulse) tc_seen++;
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 0, 0, 0);
            if (tc_pulse) tc_seen++;
        end
        check("t2_tc_once", tc_seen, 1);
        check("t2_hold0", count, 0);

        // 3. halving, then halving wins over dec
        step(0, 1, 0, 0, 0, 9, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        check("t3_half", count, 4);
        step(0, 0, 1, 1, 0, 0, 0);
        check("t3_shift_wins", count, 2);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        check("t3_div_expire_busy", busy, 0);

        // 4. prescale 2: one decrement every third edge
        step(0, 1, 1, 0, 0, 3, 2);
        for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 0, 0, 2);
        check("t4_end", count, 0);

        // 5. auto-reload cycling 2,1,0
        step(0, 1, 1, 0, 1, 2, 0);
        tc_seen = 0;
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 1, 0, 1, 0, 0);
            if (tc_pulse) tc_seen++;
        end
        check("t5_tc_count", tc_seen, 3);

        // prescale lowered below the running prescaler count
        step(0, 1, 0, 0, 0, 5, 5);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 5);
        step(0, 0, 1, 0, 0, 0, 1);
        check("pre_lowered", count, 4);

        // 6. reset mid-run at 150, then load of zero
        step(0, 1, 1, 0, 0, 200, 0);
        guard = 0;
        while (m_count != 150 && guard < 100) begin
            step(0, 0, 1, 0, 0, 0, 0);
            guard++;
        end
        check("t6_reach150", count, 150);
        step(1, 0, 1, 0, 0, 0, 0);
        check("t6_rst_count", count, 0);
        check("t6_rst_tc", tc_pulse, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1, 0, 0);
        check("t6_zero", zero, 1);
        check("t6_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
